branch_compare_seq: RTL



---
 rtl/branch_compare_seq_if.sv | 24 ++
 rtl/branch_compare_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/branch_compare_seq_if.sv
// Handshake and operand bundle between the branch stall logic and the
// iterative comparator.
interface branch_compare_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic         br_un;
  logic         busy;
  logic         done;
  logic         br_eq;
  logic         br_lt;

  modport master (
    output start, rs1_data, rs2_data, br_un,
    input  busy, done, br_eq, br_lt
  );

  modport slave (
    input  start, rs1_data, rs2_data, br_un,
    output busy, done, br_eq, br_lt
  );
endinterface

// File: rtl/branch_compare_seq.sv
// Iterative branch comparator: walks the operands STEP bits per cycle from the
// MSB chunk and stops at the first differing chunk.
module branch_compare_seq #(
  parameter int W    = 32,
  parameter int STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_compare_seq_if.slave   bus
);

  localparam int N  = W / STEP;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [KW-1:0]   r_k;
  logic            r_eq;
  logic            r_lt;

  logic            w_load;
  logic            w_decide;
  logic            w_eq_nxt;
  logic            w_lt_nxt;
  logic [STEP-1:0] w_a_chunk;
  logic [STEP-1:0] w_b_chunk;

  assign w_a_chunk = r_a[(W - 1) - int'(r_k) * STEP -: STEP];
  assign w_b_chunk = r_b[(W - 1) - int'(r_k) * STEP -: STEP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_decide    = 1'b0;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (w_a_chunk != w_b_chunk) begin
          w_decide    = 1'b1;
          w_eq_nxt    = 1'b0;
          w_lt_nxt    = (w_a_chunk < w_b_chunk);
          w_state_nxt = S_DONE;
        end else if (r_k == K_LAST) begin
          w_decide    = 1'b1;
          w_eq_nxt    = 1'b1;
          w_lt_nxt    = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CMP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the operand registers carry no reset; they are always loaded on the
  // start edge before the compare reads them.
  // Flipping the sign bits maps two's-complement order onto unsigned order.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= {bus.rs1_data[W-1] ^ ~bus.br_un, bus.rs1_data[W-2:0]};
      r_b <= {bus.rs2_data[W-1] ^ ~bus.br_un, bus.rs2_data[W-2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k  <= '0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      if (w_load) begin
        r_k <= '0;
      end else if (r_state == S_CMP && !w_decide) begin
        r_k <= r_k + KW'(1);
      end
      if (w_decide) begin
        r_eq <= w_eq_nxt;
        r_lt <= w_lt_nxt;
      end
    end
  end

  assign bus.busy  = (r_state == S_CMP);
  assign bus.done  = (r_state == S_DONE);
  assign bus.br_eq = r_eq;
  assign bus.br_lt = r_lt;

endmodule
